// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 key matrix model: plays a timed key press (with contact bounce)
// onto the active-low row lines as a wired function of the scanner's column drive.
module keypad_matrix_emulator #(
  parameter int unsigned BOUNCE_PAIRS  = 3,
  parameter int unsigned BOUNCE_PERIOD = 2,
  parameter int unsigned HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_code,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              abort,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  output logic              contact,
  output logic              busy,
  output logic              done,
  output logic [4:0]        cur_code
);

  localparam int unsigned SLOT_W    = (BOUNCE_PAIRS == 0) ? 1 : $clog2(2 * BOUNCE_PAIRS);
  localparam int unsigned TICK_W    = (BOUNCE_PERIOD <= 1) ? 1 : $clog2(BOUNCE_PERIOD);
  localparam int unsigned SLOT_LAST = (BOUNCE_PAIRS == 0) ? 0 : 2 * BOUNCE_PAIRS - 1;
  localparam int unsigned TICK_LAST = (BOUNCE_PERIOD == 0) ? 0 : BOUNCE_PERIOD - 1;

  typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [TICK_W-1:0]   tick, tick_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [HOLD_W-1:0]   hold_val, hold_val_nxt;
  logic [4:0]          code_nxt;
  logic                contact_nxt, done_nxt, ready_nxt, accept;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      tick      <= '0;
      hold_cnt  <= '0;
      hold_val  <= '0;
      contact   <= 1'b0;
      done      <= 1'b0;
      cur_code  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      tick      <= tick_nxt;
      hold_cnt  <= hold_cnt_nxt;
      hold_val  <= hold_val_nxt;
      contact   <= contact_nxt;
      done      <= done_nxt;
      cur_code  <= code_nxt;
      req_ready <= ready_nxt;
      busy      <= ~ready_nxt;
    end
  end

  // Bounce slots alternate contact; the registered contact value always
  // describes the slot the FSM is about to be in.
  always_comb begin
    state_nxt    = state;
    slot_nxt     = slot;
    tick_nxt     = tick;
    hold_cnt_nxt = hold_cnt;
    hold_val_nxt = hold_val;
    contact_nxt  = contact;
    done_nxt     = 1'b0;
    code_nxt     = cur_code;
    unique case (state)
      IDLE: begin
        contact_nxt = 1'b0;
        if (accept) begin
          code_nxt     = req_code;
          hold_val_nxt = (hold_len == '0) ? HOLD_W'(1) : hold_len;
          slot_nxt     = '0;
          tick_nxt     = '0;
          hold_cnt_nxt = '0;
          contact_nxt  = 1'b1;
          state_nxt    = (BOUNCE_PAIRS == 0) ? HOLD : PRESS_B;
        end
      end
      PRESS_B: begin
        if (tick == TICK_W'(TICK_LAST)) begin
          tick_nxt = '0;
          if (slot == SLOT_W'(SLOT_LAST)) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
            contact_nxt  = 1'b1;
          end else begin
            slot_nxt    = slot + SLOT_W'(1);
            contact_nxt = slot[0];
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt == hold_val - HOLD_W'(1)) begin
          contact_nxt = 1'b0;
          if (BOUNCE_PAIRS == 0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = REL_B;
            slot_nxt  = '0;
            tick_nxt  = '0;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      REL_B: begin
        if (tick == TICK_W'(TICK_LAST)) begin
          tick_nxt = '0;
          if (slot == SLOT_W'(SLOT_LAST)) begin
            state_nxt   = IDLE;
            contact_nxt = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            slot_nxt    = slot + SLOT_W'(1);
            contact_nxt = ~slot[0];
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      contact_nxt = 1'b0;
      done_nxt    = 1'b0;
    end
    ready_nxt = (state_nxt == IDLE);
  end

  // Wired matrix: a closed key shorts its column onto its row.
  always_comb begin
    row = 4'b1111;
    if (contact && !cur_code[4]) begin
      row[cur_code[3:2]] = col[cur_code[1:0]];
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: bounced (3x2) and clean-edge instances.
module tb_keypad_matrix_emulator;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_abort, a_contact, a_busy, a_done;
  logic [4:0]  a_req_code, a_cur_code;
  logic [15:0] a_hold_len;
  logic [3:0]  a_col, a_row;

  logic        b_req_valid, b_req_ready, b_abort, b_contact, b_busy, b_done;
  logic [4:0]  b_req_code, b_cur_code;
  logic [15:0] b_hold_len;
  logic [3:0]  b_col, b_row;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_matrix_emulator #(.BOUNCE_PAIRS(3), .BOUNCE_PERIOD(2), .HOLD_W(16)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_code(a_req_code), .hold_len(a_hold_len), .abort(a_abort), .col(a_col),
    .row(a_row), .contact(a_contact), .busy(a_busy), .done(a_done), .cur_code(a_cur_code)
  );

  keypad_matrix_emulator #(.BOUNCE_PAIRS(0), .BOUNCE_PERIOD(2), .HOLD_W(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_code(b_req_code), .hold_len(b_hold_len), .abort(b_abort), .col(b_col),
    .row(b_row), .contact(b_contact), .busy(b_busy), .done(b_done), .cur_code(b_cur_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Contact profile for 3 bounce pairs of 2 cycles, k = cycles after the accept edge.
  function automatic logic exp_contact(input int k, input int h);
    if (k <= 12)          return (((k - 1) / 2) % 2) == 0;
    else if (k <= 12 + h) return 1'b1;
    else if (k <= 24 + h) return (((k - 13 - h) / 2) % 2) == 1;
    else                  return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(input logic [4:0] code, input logic [3:0] c, input logic on);
    logic [3:0] r;
    r = 4'b1111;
    if (on && code < 5'd16) r[code / 4] = c[code % 4];
    return r;
  endfunction

  // One press on the bounced instance; optional abort/reset in cycle stop_k.
  task automatic press_a(input logic [4:0] code, input int hold, input bit walk,
                         input logic [3:0] col0, input int stop_k, input bit use_rst,
                         input bit busy_req);
    logic [3:0] walk_tab [4];
    int h, last;
    logic ec, edone, erdy;
    logic [4:0] ecode;
    walk_tab[0] = 4'b0111; walk_tab[1] = 4'b1011;
    walk_tab[2] = 4'b1101; walk_tab[3] = 4'b1110;
    h    = (hold == 0) ? 1 : hold;
    last = (stop_k != 0) ? stop_k + 3 : 25 + h;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_code = code; a_hold_len = 16'(hold); a_col = col0;
    @(posedge clk);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      a_req_valid = busy_req && (k >= 2) && (k < stop_k);
      if (a_req_valid) begin
        a_req_code = 5'd9; a_hold_len = 16'd1;
      end
      a_abort = (k == stop_k) && !use_rst;
      rst     = (k == stop_k) && use_rst;
      if (walk) a_col = walk_tab[k % 4];
      #1;
      if (stop_k != 0 && k > stop_k) begin
        ec = 1'b0; edone = 1'b0; erdy = 1'b1; ecode = use_rst ? 5'd0 : code;
      end else begin
        ec = exp_contact(k, h); edone = (k == 25 + h); erdy = edone; ecode = code;
      end
      check("contact", 32'(a_contact), 32'(ec));
      check("row", 32'(a_row), 32'(exp_row(code, a_col, ec)));
      check("done", 32'(a_done), 32'(edone));
      check("req_ready", 32'(a_req_ready), 32'(erdy));
      check("busy", 32'(a_busy), 32'(!erdy));
      check("cur_code", 32'(a_cur_code), 32'(ecode));
    end
    a_abort = 1'b0; rst = 1'b0; a_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_code = '0; a_hold_len = '0; a_abort = 1'b0; a_col = 4'hF;
    b_req_valid = 1'b0; b_req_code = '0; b_hold_len = '0; b_abort = 1'b0; b_col = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_row", 32'(a_row), 32'hF);
    check("rst_contact", 32'(a_contact), 32'h0);
    check("rst_ready", 32'(a_req_ready), 32'h1);
    check("rst_done", 32'(a_done), 32'h0);
    check("rst_cur_code", 32'(a_cur_code), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_b_ready", 32'(b_req_ready), 32'h1);
    check("rst_b_contact", 32'(b_contact), 32'h0);
    rst = 1'b0;

    press_a(5'd1, 100, 1'b0, 4'b1101, 0, 1'b0, 1'b0);   // key 1, long hold
    press_a(5'd14, 10, 1'b1, 4'b0111, 0, 1'b0, 1'b0);   // key 14, walking col
    press_a(5'd3, 40, 1'b0, 4'b0110, 20, 1'b0, 1'b1);   // abort in HOLD, busy request ignored
    press_a(5'd16, 50, 1'b1, 4'b0111, 0, 1'b0, 1'b0);   // no-key code
    press_a(5'd6, 50, 1'b0, 4'b0000, 66, 1'b1, 1'b0);   // reset during release bounce

    // Clean-edge instance: hold 0 -> 1, then back-to-back accept in the done cycle
    @(negedge clk);
    b_req_valid = 1'b1; b_req_code = 5'd5; b_hold_len = 16'd0; b_col = 4'b1101;
    @(negedge clk); b_req_valid = 1'b0; #1;
    check("b_contact_t1", 32'(b_contact), 32'h1);
    check("b_row_t1", 32'(b_row), 32'hD);
    check("b_done_t1", 32'(b_done), 32'h0);
    check("b_ready_t1", 32'(b_req_ready), 32'h0);
    check("b_code_t1", 32'(b_cur_code), 32'h5);
    @(negedge clk); #1;
    check("b_done_t2", 32'(b_done), 32'h1);
    check("b_contact_t2", 32'(b_contact), 32'h0);
    check("b_ready_t2", 32'(b_req_ready), 32'h1);
    check("b_row_t2", 32'(b_row), 32'hF);
    b_req_valid = 1'b1; b_req_code = 5'd7; b_hold_len = 16'd2; b_col = 4'b0111;
    @(negedge clk); b_req_valid = 1'b0; #1;
    check("b2_contact_1", 32'(b_contact), 32'h1);
    check("b2_code", 32'(b_cur_code), 32'h7);
    check("b2_row", 32'(b_row), 32'hD);
    check("b2_done_1", 32'(b_done), 32'h0);
    @(negedge clk); #1;
    check("b2_contact_2", 32'(b_contact), 32'h1);
    check("b2_done_2", 32'(b_done), 32'h0);
    @(negedge clk); #1;
    check("b2_done_3", 32'(b_done), 32'h1);
    check("b2_contact_3", 32'(b_contact), 32'h0);
    // abort together with an accept in IDLE: the accept wins
    b_req_valid = 1'b1; b_abort = 1'b1; b_req_code = 5'd2; b_hold_len = 16'd1;
    @(negedge clk); b_req_valid = 1'b0; b_abort = 1'b0; #1;
    check("b3_contact", 32'(b_contact), 32'h1);
    check("b3_busy", 32'(b_busy), 32'h1);
    check("b3_code", 32'(b_cur_code), 32'h2);
    @(negedge clk); #1;
    check("b3_done", 32'(b_done), 32'h1);
    @(negedge clk); #1;
    check("b3_done_clear", 32'(b_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
